// File: rtl/maze_wall_store.sv
// maze_wall_store
// Avalon-MM slave holding the 160x120-cell maze bitmap (4x4-pixel cells),
// 5 words of 32 cells per row, MSB = leftmost cell. Supplies the wall bit
// for the current pixel plus its four neighbour cells (2-cycle latency from
// DrawX/DrawY), and raises maze_ready once a complete load is committed.
//
// Ports
//   CLK, RESET_N                      clock, async active-low reset
//   AVL_CS/READ/WRITE/BYTE_EN/ADDR    Avalon-MM slave command
//   AVL_WRITEDATA, AVL_READDATA       write data in, registered read data out
//   DrawX, DrawY                      pixel coordinates
//   wall, wall_up/_down/_left/_right  wall bits for cell and neighbours
//   maze_ready                        committed maze available
//   load_error                        sticky: commit before all words written
//
// Build option: define MAZE_BORDER_EN to force the outermost ring of cells
// to read as wall regardless of stored data.
//
// state   | meaning
// IDLE    | nothing loaded since reset
// LOADING | maze words being written, not yet committed
// READY   | committed maze available
module maze_wall_store #(
    parameter int unsigned MAZE_WORDS    = 600,
    parameter int unsigned WORDS_PER_ROW = 5,
    parameter int unsigned CELL_SHIFT    = 2,
    parameter int unsigned CTRL_ADDR     = 1023
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic        AVL_CS,
    input  logic [3:0]  AVL_BYTE_EN,
    input  logic [9:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        wall,
    output logic        wall_up,
    output logic        wall_down,
    output logic        wall_left,
    output logic        wall_right,
    output logic        maze_ready,
    output logic        load_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_READY   = 2'd2
    } state_t;

    logic [31:0] mem_q [MAZE_WORDS];
    logic [31:0] wr_word;
    logic        maze_wr, ctrl_wr;
    logic [31:0] ctrl_word;

    state_t      state_q, state_d;
    logic [10:0] wcount_q, wcount_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]  cx_q, cx_d, cy_q, cy_d;
    logic [9:0]  word_q, word_d;
    logic [4:0]  bit_q, bit_d;
    logic        off_q, off_d;

    logic        wall_q, wall_d, up_q, up_d, down_q, down_d;
    logic        left_q, left_d, right_q, right_d;
    logic        f_c, f_up, f_dn, f_lt, f_rt;
    logic [9:0]  w_lt, w_rt;
    logic [4:0]  b_lt, b_rt;

    assign maze_wr   = AVL_CS && AVL_WRITE && (AVL_ADDR < 10'(MAZE_WORDS));
    assign ctrl_wr   = AVL_CS && AVL_WRITE && (AVL_ADDR == 10'(CTRL_ADDR));
    assign ctrl_word = {18'b0, err_q, state_q, wcount_q};

    always_comb begin
        wr_word = mem_q[AVL_ADDR];
        for (int b = 0; b < 4; b++) begin
            if (AVL_BYTE_EN[b]) wr_word[8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        wcount_d = wcount_q;
        err_d    = err_q;
        if (maze_wr) begin
            if (state_q == S_LOADING) begin
                if (wcount_q != 11'(MAZE_WORDS)) wcount_d = wcount_q + 11'd1;
            end else begin
                wcount_d = 11'd1;
                state_d  = S_LOADING;
            end
        end
        // Clear is applied before the commit is evaluated, so a combined
        // clear+failed-commit leaves the error set.
        if (ctrl_wr) begin
            if (AVL_WRITEDATA[1]) err_d = 1'b0;
            if (AVL_WRITEDATA[0] && state_q == S_LOADING) begin
                if (wcount_q == 11'(MAZE_WORDS)) state_d = S_READY;
                else                             err_d   = 1'b1;
            end
        end
        ready_d = (state_d == S_READY);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (AVL_CS && AVL_READ) begin
            if (AVL_ADDR < 10'(MAZE_WORDS))        rdata_d = mem_q[AVL_ADDR];
            else if (AVL_ADDR == 10'(CTRL_ADDR))   rdata_d = ctrl_word;
            else                                   rdata_d = '0;
        end
    end

    // Stage 1: cell coordinates and word/bit position of the centre cell.
    always_comb begin
        cx_d   = DrawX[CELL_SHIFT +: 8];
        cy_d   = DrawY[CELL_SHIFT +: 8];
        off_d  = (DrawX >= 10'd640) || (DrawY >= 10'd480);
        bit_d  = ~cx_d[4:0];
        word_d = '0;
        if (!off_d) word_d = {2'b0, cy_d} * 10'(WORDS_PER_ROW) + {7'b0, cx_d[7:5]};
    end

    // Stage 2: neighbour positions derived from the centre word/bit.
    // Left/right cross a word boundary when the centre is bit 31/bit 0.
    always_comb begin
        w_lt = (bit_q == 5'd31) ? word_q - 10'd1 : word_q;
        b_lt = bit_q + 5'd1;
        w_rt = (bit_q == 5'd0)  ? word_q + 10'd1 : word_q;
        b_rt = bit_q - 5'd1;
`ifdef MAZE_BORDER_EN
        f_c  = (cx_q == 8'd0) || (cx_q == 8'd159) || (cy_q == 8'd0) || (cy_q == 8'd119);
        f_up = (cy_q <= 8'd1)   || (cx_q == 8'd0) || (cx_q == 8'd159);
        f_dn = (cy_q >= 8'd118) || (cx_q == 8'd0) || (cx_q == 8'd159);
        f_lt = (cx_q <= 8'd1)   || (cy_q == 8'd0) || (cy_q == 8'd119);
        f_rt = (cx_q >= 8'd158) || (cy_q == 8'd0) || (cy_q == 8'd119);
`else
        f_c  = 1'b0;
        f_up = (cy_q == 8'd0);
        f_dn = (cy_q == 8'd119);
        f_lt = (cx_q == 8'd0);
        f_rt = (cx_q == 8'd159);
`endif
        wall_d  = (off_q || f_c)  ? 1'b1 : mem_q[word_q][bit_q];
        up_d    = (off_q || f_up) ? 1'b1 : mem_q[word_q - 10'(WORDS_PER_ROW)][bit_q];
        down_d  = (off_q || f_dn) ? 1'b1 : mem_q[word_q + 10'(WORDS_PER_ROW)][bit_q];
        left_d  = (off_q || f_lt) ? 1'b1 : mem_q[w_lt][b_lt];
        right_d = (off_q || f_rt) ? 1'b1 : mem_q[w_rt][b_rt];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(MAZE_WORDS); i++) mem_q[i] <= '0;
        end else if (maze_wr) begin
            mem_q[AVL_ADDR] <= wr_word;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            wcount_q <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            word_q   <= '0;
            bit_q    <= '0;
            off_q    <= 1'b0;
            wall_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcount_q <= wcount_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
            off_q    <= off_d;
            wall_q   <= wall_d;
            up_q     <= up_d;
            down_q   <= down_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign AVL_READDATA = rdata_q;
    assign wall         = wall_q;
    assign wall_up      = up_q;
    assign wall_down    = down_q;
    assign wall_left    = left_q;
    assign wall_right   = right_q;
    assign maze_ready   = ready_q;
    assign load_error   = err_q;

endmodule

// File: tb/tb_maze_wall_store.sv
// Directed bench for maze_wall_store: Avalon load/commit sequencing,
// byte-enable writes, readback, and wall/neighbour lookup.
module tb_maze_wall_store;

`ifdef MAZE_BORDER_EN
    localparam logic [31:0] BRD = 32'd1;
`else
    localparam logic [31:0] BRD = 32'd0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
    logic [3:0]  AVL_BYTE_EN = 4'h0;
    logic [9:0]  AVL_ADDR = '0;
    logic [31:0] AVL_WRITEDATA = '0;
    logic [31:0] AVL_READDATA;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        wall, wall_up, wall_down, wall_left, wall_right, maze_ready, load_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    maze_wall_store dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .DrawX(DrawX), .DrawY(DrawY),
        .wall(wall), .wall_up(wall_up), .wall_down(wall_down),
        .wall_left(wall_left), .wall_right(wall_right),
        .maze_ready(maze_ready), .load_error(load_error)
    );

    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic avl_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input logic [9:0] a, output logic [31:0] d);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        d = AVL_READDATA;
    endtask

    task automatic lookup(input logic [9:0] x, input logic [9:0] y);
        @(negedge CLK);
        DrawX = x; DrawY = y;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_wall", 32'(wall), 32'd0);
        check("rst_ready", 32'(maze_ready), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_rdata", AVL_READDATA, 32'd0);
        RESET_N = 1'b1;

        avl_read(10'd1023, rd);
        check("ctrl_after_rst", rd, 32'h0);
        lookup(10'd100, 10'd100);
        check("wall_100_100", 32'(wall), 32'd0);
        lookup(10'd100, 10'd0);
        check("up_at_top", 32'(wall_up), 32'd1);

        avl_write(10'd0, 32'h8000_0000, 4'hF);
        lookup(10'd0, 10'd0);
        check("wall_0_0", 32'(wall), 32'd1);
        check("right_0_0", 32'(wall_right), BRD);
        check("left_0_0", 32'(wall_left), 32'd1);
        check("down_0_0", 32'(wall_down), BRD);

        avl_write(10'd5, 32'hFFFF_FFFF, 4'b0001);
        avl_read(10'd5, rd);
        check("rd_byte_en", rd, 32'h0000_00FF);
        @(negedge CLK);
        check("rd_hold", AVL_READDATA, 32'h0000_00FF);
        lookup(10'd124, 10'd4);
        check("wall_31_1", 32'(wall), 32'd1);
        check("up_31_1", 32'(wall_up), BRD);
        check("left_31_1", 32'(wall_left), 32'd1);
        check("right_31_1", 32'(wall_right), 32'd0);

        avl_write(10'd0, 32'h0000_0001, 4'hF);
        avl_write(10'd1, 32'h8000_0000, 4'hF);
        lookup(10'd124, 10'd0);
        check("wall_x124", 32'(wall), 32'd1);
        check("right_cross_word", 32'(wall_right), 32'd1);
        check("left_x124", 32'(wall_left), BRD);
        lookup(10'd128, 10'd0);
        check("left_cross_word", 32'(wall_left), 32'd1);

        avl_read(10'd1023, rd);
        check("ctrl_wcount4", rd, 32'h0000_0804);
        avl_write(10'd700, 32'hFFFF_FFFF, 4'hF);
        avl_read(10'd700, rd);
        check("rd_gap_addr", rd, 32'h0);

        lookup(10'd640, 10'd100);
        check("off_x_wall", 32'(wall), 32'd1);
        check("off_x_left", 32'(wall_left), 32'd1);
        lookup(10'd100, 10'd480);
        check("off_y_up", 32'(wall_up), 32'd1);
        lookup(10'd636, 10'd100);
        check("right_edge_right", 32'(wall_right), 32'd1);
        check("right_edge_wall", 32'(wall), BRD);

        avl_write(10'd4, 32'h0, 4'hF);
        for (int a = 6; a < 600; a++) avl_write(10'(a), 32'h0, 4'hF);
        avl_write(10'd1023, 32'h1, 4'hF);
        check("short_commit_err", 32'(load_error), 32'd1);
        check("short_commit_rdy", 32'(maze_ready), 32'd0);
        avl_read(10'd1023, rd);
        check("ctrl_599_err", rd, 32'h0000_2A57);

        avl_write(10'd4, 32'h0, 4'hF);
        avl_write(10'd4, 32'h0, 4'hF);
        avl_read(10'd1023, rd);
        check("ctrl_wcount_sat", rd, 32'h0000_2A58);
        avl_write(10'd1023, 32'h3, 4'hF);
        check("commit_ready", 32'(maze_ready), 32'd1);
        check("commit_err_clr", 32'(load_error), 32'd0);
        avl_read(10'd1023, rd);
        check("ctrl_ready", rd, 32'h0000_1258);
        avl_write(10'd1023, 32'h1, 4'hF);
        avl_read(10'd1023, rd);
        check("commit_in_ready", rd, 32'h0000_1258);

        avl_write(10'd10, 32'h0, 4'hF);
        check("reload_drops_ready", 32'(maze_ready), 32'd0);
        avl_read(10'd1023, rd);
        check("ctrl_reload", rd, 32'h0000_0801);
        avl_write(10'd1023, 32'h1, 4'hF);
        check("err_mid_load", 32'(load_error), 32'd1);
        lookup(10'd124, 10'd4);
        check("wall_before_rst", 32'(wall), 32'd1);

        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("arst_err", 32'(load_error), 32'd0);
        check("arst_wall", 32'(wall), 32'd0);
        check("arst_rdata", AVL_READDATA, 32'd0);
        check("arst_ready", 32'(maze_ready), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        avl_read(10'd5, rd);
        check("maze_cleared", rd, 32'h0);
        lookup(10'd124, 10'd4);
        check("wall_cleared", 32'(wall), 32'd0);
        avl_read(10'd1023, rd);
        check("ctrl_cleared", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
